// File: rtl/four_bit_cpu_pkg.sv
// Shared types and constants for the FourBitCPU program sequencer.
package four_bit_cpu_pkg;

    localparam int STORE_DEPTH = 16;
    localparam int ADDR_W      = 4;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DONE
    } drv_state_t;

    // Field order fixes the packed layout of captured flags as {s, z, c}.
    typedef struct packed {
        logic s;
        logic z;
        logic c;
    } cpu_flags_t;

endpackage

// File: rtl/cpu_prog_store.sv
// Paired 16x8 program/operand stores: synchronous write, combinational read.
module cpu_prog_store
    import four_bit_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wprog,
    input  logic [BYTE_W-1:0] winp,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rprog,
    output logic [BYTE_W-1:0] rinp
);

    logic [BYTE_W-1:0] prog_mem [STORE_DEPTH];
    logic [BYTE_W-1:0] inp_mem  [STORE_DEPTH];

    // NOTE: the arrays have no reset so they map onto plain RAM/regfile cells;
    // non-blocking writes keep a same-edge read returning the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            prog_mem[waddr] <= wprog;
            inp_mem[waddr]  <= winp;
        end
    end

    assign rprog = prog_mem[raddr];
    assign rinp  = inp_mem[raddr];

endmodule

// File: rtl/four_bit_cpu_driver.sv
// Program sequencer for FourBitCPU: primes the CPU, streams store bytes each
// RUN cycle and captures the result on HLT or when the step limit expires.
module four_bit_cpu_driver
    import four_bit_cpu_pkg::*;
#(
    parameter int MAX_STEPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [BYTE_W-1:0] load_prog,
    input  logic [BYTE_W-1:0] load_inp,
    input  logic              start,
    output logic              cpu_rst,
    output logic [BYTE_W-1:0] myprogram,
    output logic [BYTE_W-1:0] myinput,
    input  logic [BYTE_W-1:0] myoutput,
    input  logic              HLT,
    input  logic              s_flag,
    input  logic              z_flag,
    input  logic              c_flag,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [BYTE_W-1:0] result,
    output logic [2:0]        result_flags,
    output logic [7:0]        run_cycles
);

    localparam logic [7:0] STEP_LAST = 8'(MAX_STEPS - 1);

    drv_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        steps;
    logic              store_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [BYTE_W-1:0] rd_prog, rd_inp;
    logic              finish_run;
    cpu_flags_t        flags_now;

    assign store_we   = load_en && (state == ST_IDLE);
    // IDLE reads entry 0 so the first byte is ready on the start edge.
    assign rd_addr    = (state == ST_IDLE) ? '0 : pc;
    assign finish_run = HLT || (steps == STEP_LAST);
    assign flags_now  = '{s: s_flag, z: z_flag, c: c_flag};

    cpu_prog_store u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (load_addr),
        .wprog (load_prog),
        .winp  (load_inp),
        .raddr (rd_addr),
        .rprog (rd_prog),
        .rinp  (rd_inp)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cpu_rst   = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_PRIME;
            ST_PRIME: begin
                busy      = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy    = 1'b1;
                cpu_rst = 1'b0;
                if (finish_run) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            steps        <= '0;
            myprogram    <= '0;
            myinput      <= '0;
            timeout      <= 1'b0;
            result       <= '0;
            result_flags <= '0;
            run_cycles   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        myprogram    <= rd_prog;
                        myinput      <= rd_inp;
                        pc           <= ADDR_W'(1);
                        steps        <= '0;
                        timeout      <= 1'b0;
                        result       <= '0;
                        result_flags <= '0;
                        run_cycles   <= '0;
                    end
                end
                ST_RUN: begin
                    if (finish_run) begin
                        result       <= myoutput;
                        result_flags <= flags_now;
                        run_cycles   <= steps + 8'd1;
                        // HLT has priority, so a coincident limit is not a timeout.
                        timeout      <= !HLT;
                    end else begin
                        myprogram <= rd_prog;
                        myinput   <= rd_inp;
                        pc        <= pc + ADDR_W'(1);
                        steps     <= steps + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_four_bit_cpu_driver.sv
// Directed bench for four_bit_cpu_driver; three instances share stimulus and
// differ only in MAX_STEPS (16, 18 to expose pc wrap, 1 for the limit corner).
module tb_four_bit_cpu_driver;

    localparam int RUN_WINDOW = 24;

    logic       clk = 1'b0;
    logic       rst, load_en, start, hlt, s_flag, z_flag, c_flag;
    logic [3:0] load_addr;
    logic [7:0] load_prog, load_inp, myoutput;

    logic       cpu_rst, busy, done, timeout;
    logic [7:0] myprogram, myinput, result, run_cycles;
    logic [2:0] result_flags;

    logic       w_cpu_rst, w_busy, w_done, w_timeout;
    logic [7:0] w_myprogram, w_myinput, w_result, w_run_cycles;
    logic [2:0] w_result_flags;

    logic       o_cpu_rst, o_busy, o_done, o_timeout;
    logic [7:0] o_myprogram, o_myinput, o_result, o_run_cycles;
    logic [2:0] o_result_flags;

    int n_tests = 0;
    int n_fail  = 0;

    int         n_run, done_cnt, done_cyc, w_n, w_done_cnt;
    logic [7:0] obs_prog [32];
    logic [7:0] obs_inp  [32];
    logic [7:0] w_prog   [32];
    logic [7:0] prime_prog, prime_inp;
    logic       prime_busy, prime_cpu_rst;

    always #5 clk = ~clk;

    four_bit_cpu_driver dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_prog(load_prog), .load_inp(load_inp), .start(start),
        .cpu_rst(cpu_rst), .myprogram(myprogram), .myinput(myinput),
        .myoutput(myoutput), .HLT(hlt), .s_flag(s_flag), .z_flag(z_flag),
        .c_flag(c_flag), .busy(busy), .done(done), .timeout(timeout),
        .result(result), .result_flags(result_flags), .run_cycles(run_cycles)
    );

    four_bit_cpu_driver #(.MAX_STEPS(18)) dut_w (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_prog(load_prog), .load_inp(load_inp), .start(start),
        .cpu_rst(w_cpu_rst), .myprogram(w_myprogram), .myinput(w_myinput),
        .myoutput(myoutput), .HLT(hlt), .s_flag(s_flag), .z_flag(z_flag),
        .c_flag(c_flag), .busy(w_busy), .done(w_done), .timeout(w_timeout),
        .result(w_result), .result_flags(w_result_flags), .run_cycles(w_run_cycles)
    );

    four_bit_cpu_driver #(.MAX_STEPS(1)) dut_1 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_prog(load_prog), .load_inp(load_inp), .start(start),
        .cpu_rst(o_cpu_rst), .myprogram(o_myprogram), .myinput(o_myinput),
        .myoutput(myoutput), .HLT(hlt), .s_flag(s_flag), .z_flag(z_flag),
        .c_flag(c_flag), .busy(o_busy), .done(o_done), .timeout(o_timeout),
        .result(o_result), .result_flags(o_result_flags), .run_cycles(o_run_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Store image: prog[i] = {i+1, i+1} (4-bit, so entry 15 is 8'h00), inp[i] = A0+i.
    function automatic logic [7:0] exp_prog(input int i);
        logic [3:0] k;
        k = 4'(i + 1);
        return {k, k};
    endfunction

    function automatic logic [7:0] exp_inp(input int i);
        return 8'hA0 + 8'(i);
    endfunction

    // Called right after a negedge. Pulses start, records the PRIME cycle,
    // then watches a fixed window of negedges; hlt_at counts RUN edges (0 = never).
    task automatic run(input int hlt_at, input int ign_at,
                       input logic [7:0] out_v, input logic [2:0] flg_v);
        n_run = 0; done_cnt = 0; done_cyc = -1; w_n = 0; w_done_cnt = 0;
        myoutput = out_v;
        {s_flag, z_flag, c_flag} = flg_v;
        hlt   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        prime_prog    = myprogram;
        prime_inp     = myinput;
        prime_busy    = busy;
        prime_cpu_rst = cpu_rst;
        for (int cyc = 1; cyc < RUN_WINDOW; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (w_done) w_done_cnt++;
            if (!cpu_rst && n_run < 32) begin
                obs_prog[n_run] = myprogram;
                obs_inp[n_run]  = myinput;
                n_run++;
            end
            if (!w_cpu_rst && w_n < 32) begin
                w_prog[w_n] = w_myprogram;
                w_n++;
            end
            hlt = (hlt_at != 0) && !cpu_rst && (n_run == hlt_at);
            if (cyc == ign_at) begin
                start = 1'b1; load_en = 1'b1;
                load_addr = 4'd5; load_prog = 8'hFF; load_inp = 8'hEE;
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
        check({tag, "_prog"}, myprogram, 8'h00);
        check({tag, "_inp"}, myinput, 8'h00);
        check({tag, "_result"}, result, 8'h00);
        check({tag, "_flags"}, result_flags, 3'b000);
        check({tag, "_cycles"}, run_cycles, 8'h00);
        check({tag, "_busy_done_to"}, {busy, done, timeout}, 3'b000);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; start = 1'b0; hlt = 1'b0;
        load_addr = '0; load_prog = '0; load_inp = '0;
        myoutput = '0; s_flag = 1'b0; z_flag = 1'b0; c_flag = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_en = 1'b1; load_addr = 4'(i);
            load_prog = exp_prog(i); load_inp = exp_inp(i);
        end
        @(negedge clk);
        load_en = 1'b0;

        // HLT on third RUN edge.
        run(3, 0, 8'h5C, 3'b001);
        check("a_prime_bytes", {prime_prog, prime_inp}, 16'h11A0);
        check("a_prime_ctl", {prime_busy, prime_cpu_rst}, 2'b11);
        check("a_nrun", n_run, 3);
        check("a_bytes0", {obs_prog[0], obs_inp[0]}, 16'h11A0);
        check("a_bytes1", {obs_prog[1], obs_inp[1]}, 16'h22A1);
        check("a_bytes2", {obs_prog[2], obs_inp[2]}, 16'h33A2);
        check("a_done_cnt", done_cnt, 1);
        check("a_done_cyc", done_cyc, 4);
        check("a_result", result, 8'h5C);
        check("a_flags", result_flags, 3'b001);
        check("a_cycles", run_cycles, 8'd3);
        check("a_timeout", timeout, 1'b0);
        check("a_idle", {busy, cpu_rst}, 2'b01);

        // No HLT: step limit, with a start and a store write attempted mid-run.
        run(0, 5, 8'h3E, 3'b010);
        check("b_nrun", n_run, 16);
        check("b_last_bytes", {obs_prog[15], obs_inp[15]}, 16'h00AF);
        check("b_done_cnt", done_cnt, 1);
        check("b_timeout", timeout, 1'b1);
        check("b_cycles", run_cycles, 8'd16);
        check("b_result", {result, 5'b0, result_flags}, 16'h3E02);
        check("b_idle_after", busy, 1'b0);
        check("b_wrap_nrun", w_n, 18);
        check("b_wrap_p15", w_prog[15], 8'h00);
        check("b_wrap_p16", w_prog[16], 8'h11);
        check("b_wrap_p17", w_prog[17], 8'h22);
        check("b_wrap_done", w_done_cnt, 1);
        check("b_wrap_end", {w_timeout, w_run_cycles}, {1'b1, 8'd18});
        check("b_lim1_end", {o_timeout, o_run_cycles}, {1'b1, 8'd1});

        // Dropped write must leave prog[5] / inp[5] intact.
        run(6, 0, 8'h07, 3'b000);
        check("c_p5", {obs_prog[5], obs_inp[5]}, 16'h66A5);
        check("c_cycles", run_cycles, 8'd6);
        check("c_timeout", timeout, 1'b0);

        // HLT on first RUN edge; coincides with the limit on the MAX_STEPS=1 copy.
        run(1, 0, 8'hC3, 3'b110);
        check("d_done_cyc", done_cyc, 2);
        check("d_done_cnt", done_cnt, 1);
        check("d_cycles", run_cycles, 8'd1);
        check("d_result", {result, 5'b0, result_flags}, 16'hC306);
        check("d_lim1_timeout", o_timeout, 1'b0);
        check("d_lim1_cycles", o_run_cycles, 8'd1);
        check("d_lim1_result", o_result, 8'hC3);

        // Reset mid-run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("e_in_run", {busy, cpu_rst}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("e_abort");
        rst = 1'b0;

        // Start together with a write to entry 0: PRIME still sees the old byte.
        load_en = 1'b1; load_addr = 4'd0; load_prog = 8'h5A; load_inp = 8'h55;
        run(2, 0, 8'h80, 3'b100);
        check("e_prime_old", {prime_prog, prime_inp}, 16'h11A0);
        check("e_bytes1", {obs_prog[1], obs_inp[1]}, 16'h22A1);
        check("e_result", {result, 5'b0, result_flags}, 16'h8004);
        check("e_cycles", run_cycles, 8'd2);

        run(1, 0, 8'h01, 3'b000);
        check("f_new_p0", {obs_prog[0], obs_inp[0]}, 16'h5A55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/four_bit_cpu_driver.md
# four_bit_cpu_driver

Initiator-side program sequencer for the FourBitCPU core. It holds a 16-entry program store and a 16-entry operand store, loaded over a simple write port. On `start` it holds the CPU in reset for one cycle, then streams one program byte and one operand byte per clock on `myprogram`/`myinput`. It captures `myoutput` and the flags when the CPU raises `HLT`, or when a step limit expires.

## Interface
Parameters:
- `MAX_STEPS`, default 16: maximum RUN cycles before timeout; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_en`  in  1  write strobe for the stores; honoured only in IDLE.
- `load_addr`  in  4  store address.
- `load_prog`  in  8  byte written to program store at `load_addr`.
- `load_inp`  in  8  byte written to operand store at `load_addr`.
- `start`  in  1  begin a run; honoured only in IDLE.
- `cpu_rst`  out  1  reset to CPU; 1 in every state except RUN.
- `myprogram`  out  8  instruction byte to CPU (registered).
- `myinput`  out  8  operand byte to CPU (registered).
- `myoutput`  in  8  CPU result.
- `HLT`  in  1  CPU halt indication.
- `s_flag`, `z_flag`, `c_flag`  in  1 each  CPU flags.
- `busy`  out  1  high in PRIME and RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `timeout`  out  1  last run ended on the step limit, not on `HLT`.
- `result`  out  8  captured `myoutput`.
- `result_flags`  out  3  captured {s, z, c}.
- `run_cycles`  out  8  RUN cycles consumed, including the capture cycle.

## Operation
- Reset: state IDLE, `pc`=0, steps=0.
  - Outputs after reset: `cpu_rst`=1; `myprogram`, `myinput`, `result`=0; `result_flags`=0; `run_cycles`=0; `busy`, `done`, `timeout`=0.
  - Stores are not cleared.
- Stores: 16×8 each. A write is performed when `load_en` is high and state is IDLE. Writes in other states are dropped.
- FSM states: IDLE, PRIME, RUN, DONE.
- IDLE → PRIME on `start`. On that edge:
  - `myprogram`<=prog[0], `myinput`<=inp[0], `pc`<=1, steps<=0.
  - `timeout`<=0; `result`, `result_flags`, `run_cycles` cleared.
- PRIME → RUN unconditionally. This is the cycle where `cpu_rst` is still 1 with the first byte already presented.
- RUN, evaluated each edge in priority order:
  1. `HLT`=1: `result`<=`myoutput`, `result_flags`<={s,z,c}, `run_cycles`<=steps+1, go to DONE.
  2. Else if steps==MAX_STEPS-1: capture as in (1), `timeout`<=1, go to DONE.
  3. Else: `myprogram`<=prog[`pc`], `myinput`<=inp[`pc`], `pc`<=`pc`+1 (4-bit; 15 wraps to 0), steps<=steps+1.
- DONE → IDLE unconditionally.
- Results hold until the next `start`.
- `start` or `load_en` outside IDLE is ignored. Nothing is queued.
- `load_en` and `start` in the same IDLE cycle: the write and the start are both taken. If `load_addr`=0, PRIME reads the old prog[0], because the store read happens on the same edge as the write.

## Timing
- `start` sampled at edge T0. Then:
  - `busy`=1 from T0+.
  - `cpu_rst` falls after T1.
  - First CPU-visible clock with `cpu_rst`=0 is T2, with prog[0] on `myprogram`.
- Each subsequent RUN cycle advances one store entry.
- `HLT` sampled at edge Tn in RUN → `result` valid and `done`=1 during Tn..Tn+1. IDLE from Tn+1.
- Minimum run (`HLT` on first RUN edge) is 4 cycles from `start` to IDLE: `run_cycles`=1.
- `rst` mid-run aborts immediately to reset values. `cpu_rst` returns to 1 the next cycle.
- `HLT` and step limit reached together: `HLT` wins, `timeout`=0.

## Structure
- Shared package `four_bit_cpu_pkg`: FSM state enum, store depth constant (16), address width (4), flag vector ordering {s,z,c}.
- One natural sub-module: `cpu_prog_store` (dual 16×8 arrays, synchronous write, combinational read by address). FSM, counters and capture logic stay in the top.

## Test plan
- Load prog[0..3]=8'h11,8'h22,8'h33,8'h44 and inp[0..3]=8'hA0..8'hA3; `start`; CPU model asserts `HLT` on the 3rd RUN edge with `myoutput`=8'h5C, s=0, z=0, c=1 → bytes observed in order 11/A0, 22/A1, 33/A2; `result`=8'h5C, `result_flags`=3'b001, `run_cycles`=3, `timeout`=0, `done` one cycle.
- `HLT` never asserted, `MAX_STEPS`=16 → `pc` wraps 15→0, `timeout`=1, `run_cycles`=16, `done` pulses once, IDLE after.
- `load_en` with addr 5 / prog 8'hFF during RUN → prog[5] unchanged on a subsequent run; second `start` during RUN ignored (`run_cycles` unaffected).
- `rst` asserted in RUN → next cycle: all outputs at reset values, `cpu_rst`=1; new `start` then runs normally.
- `HLT` on first RUN edge → `run_cycles`=1, `done` exactly 3 cycles after `start`; `HLT` coinciding with the step limit (`MAX_STEPS`=1) → `timeout`=0.
